// File: rtl/add16_pkg.sv
// Shared width and operand/result types for the 16-bit ripple adder.
package add16_pkg;

    localparam int ADD_WIDTH = 16;

    typedef logic [ADD_WIDTH-1:0] operand_t;

    typedef struct packed {
        logic     carry;
        operand_t sum;
    } result_t;

endpackage

// File: rtl/full_adder_1b.sv
// 1-bit full adder cell for the ripple chain.
// Latency: combinational. Backpressure: none.
// Has no storage and no flow control.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/add16_bits.sv
// Registered WIDTH-bit ripple-carry adder: {carry_out, sum} = a + b + carry_in.
// Latency: 1 cycle, 1 result per cycle. Backpressure: none, captures whenever in_valid is high.
// Optional overflow/zero flag outputs are built when ADD16_FLAGS_EN is defined.
module add16_bits
    import add16_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef ADD16_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;

    assign carry[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_1b u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Operands are only observed on valid cycles, so idle junk never reaches the outputs.
            if (in_valid) begin
                sum       <= s;
                carry_out <= carry[WIDTH];
            end
        end
    end

`ifdef ADD16_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (in_valid) begin
            // Signed overflow: carry into the sign bit differs from carry out of it.
            overflow <= carry[WIDTH] ^ carry[WIDTH-1];
            zero     <= (s == '0);
        end
    end
`endif

endmodule

// File: tb/tb_add16_bits.sv
// Directed plus random bench for add16_bits against an arithmetic reference model.
module tb_add16_bits;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        out_valid;
    logic [15:0] sum;
    logic        carry_out;
`ifdef ADD16_FLAGS_EN
    logic        overflow;
    logic        zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the outputs should show right now.
    logic        m_vld;
    logic [15:0] m_sum;
    logic        m_co;
    logic        m_ov;
    logic        m_z;

    add16_bits #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef ADD16_FLAGS_EN
        ,
        .overflow  (overflow),
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        check({tag, ".sum"},       32'(sum),       32'(m_sum));
        check({tag, ".carry_out"}, 32'(carry_out), 32'(m_co));
`ifdef ADD16_FLAGS_EN
        check({tag, ".overflow"},  32'(overflow),  32'(m_ov));
        check({tag, ".zero"},      32'(zero),      32'(m_z));
`endif
    endtask

    task automatic model_reset();
        m_vld = 1'b0;
        m_sum = 16'h0;
        m_co  = 1'b0;
        m_ov  = 1'b0;
        m_z   = 1'b0;
    endtask

    // Drive one cycle of inputs, then compare every output just after the edge.
    task automatic step(input string tag, input logic v, input logic [15:0] ta,
                        input logic [15:0] tb_, input logic ci);
        logic [16:0] r;
        @(negedge clk);
        in_valid = v;
        a        = ta;
        b        = tb_;
        carry_in = ci;
        @(posedge clk);
        #1;
        m_vld = v;
        if (v) begin
            r     = 17'(ta) + 17'(tb_) + 17'(ci);
            m_sum = r[15:0];
            m_co  = r[16];
            m_ov  = (ta[15] == tb_[15]) && (r[15] != ta[15]);
            m_z   = (r[15:0] == 16'h0);
        end
        check_all(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        carry_in = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("zero_add",  1'b1, 16'h0000, 16'h0000, 1'b0);
        check("zero_add.const_sum", 32'(sum), 32'h0);
        step("wrap",      1'b1, 16'hFFFF, 16'h0001, 1'b0);
        check("wrap.const_co", 32'(carry_out), 32'h1);
        step("full",      1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        check("full.const_sum", 32'(sum), 32'hFFFF);
        step("s_ovf",     1'b1, 16'h7FFF, 16'h0001, 1'b0);
        check("s_ovf.const_sum", 32'(sum), 32'h8000);
        step("cap_1234",  1'b1, 16'h1234, 16'h1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 16'hAAAA, 16'h5555, 1'b1);
            check("hold.const_sum", 32'(sum), 32'h2345);
        end

        // Random mix of back-to-back and idle cycles.
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                 1'($urandom));
        end

        // Asynchronous reset between clock edges after a capture.
        step("pre_rst", 1'b1, 16'hC0DE, 16'h1F2E, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            carry_in = 1'b1;
            @(posedge clk);
            #1;
            check_all("rst_held");
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        step("post_rst",  1'b1, 16'h8000, 16'h8000, 1'b0);
        step("post_rst2", 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
        step("idle_end",  1'b0, 16'h0,    16'h0,    1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/add16_bits.md
Name: add16_bits

Overview:
- Registered 16-bit binary adder with carry-in and carry-out, built from a ripple chain of 1-bit full adders.
- Computes {carry_out, sum} = a + b + carry_in and presents the result one clock after a valid input.
- Leaf arithmetic block for the ALU datapath. Standalone, with no downstream backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits. Only 16 is verified; the ripple chain is generated over WIDTH.

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a, b and carry_in are valid this cycle; capture them
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- carry_in  input  1  carry into bit 0
- out_valid  output  1  sum and carry_out hold a fresh result this cycle
- sum  output  WIDTH  registered sum bits [WIDTH-1:0]
- carry_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Combinational core:
  - A ripple chain of WIDTH full adders.
  - Bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = carry_in.
  - The result equals the (WIDTH+1)-bit unsigned sum a + b + carry_in.
- Capture: on a clk rising edge with in_valid=1, register sum <= s and carry_out <= c_WIDTH.
- Hold: on a rising edge with in_valid=0, sum and carry_out keep their previous values.
- Valid timing:
  - out_valid <= in_valid on every rising edge.
  - Latency is exactly 1 cycle and throughput is 1 result per cycle.
  - Back-to-back valid inputs each produce a result on the following cycle.
- Reset:
  - rst_n=0 asynchronously forces sum=0, carry_out=0, out_valid=0, regardless of clk.
  - Reset asserted mid-operation discards any in-flight result.
  - The first capture occurs on the first rising edge after rst_n deasserts with in_valid=1.
- Wrap-around: the maximum sum is 0xFFFF+0xFFFF+1 = 0x1FFFF, giving sum=0xFFFF and carry_out=1. No saturation.
- No X propagation from unused inputs: operands are ignored while in_valid=0.

Optional Feature:
- Macro ADD16_FLAGS_EN.
- When defined, the block adds two registered outputs, captured under the same in_valid rule, holding when in_valid=0 and reset to 0:
  - overflow (1 bit): signed two's-complement overflow, c_WIDTH ^ c_(WIDTH-1).
  - zero (1 bit): high when the WIDTH-bit sum == 0.
- When undefined, these ports and registers do not exist and the block's behaviour is unchanged.

Decomposition:
- Package add16_pkg:
  - ADD_WIDTH = 16.
  - A typedef for a WIDTH-bit operand word.
  - A typedef for the (WIDTH+1)-bit result {carry, sum}.
- Sub-module full_adder_1b:
  - Purely combinational.
  - Ports a, b, cin, s, cout.
  - Instantiated WIDTH times in a generate loop inside add16_bits.
- All registers live in add16_bits.

Test Plan:
- Zero add: in_valid=1, a=0x0000, b=0x0000, carry_in=0 -> next cycle sum=0x0000, carry_out=0, out_valid=1; with flags, zero=1, overflow=0.
- Wrap: a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1; with flags, zero=1, overflow=0.
- Full carry: a=0xFFFF, b=0xFFFF, carry_in=1 -> sum=0xFFFF, carry_out=1.
- Signed overflow: a=0x7FFF, b=0x0001, carry_in=0 -> sum=0x8000, carry_out=0; with flags, overflow=1.
- Hold and valid:
  - Capture 0x1234+0x1111 -> sum=0x2345.
  - Then drive a=0xAAAA with in_valid=0 for 3 cycles -> sum stays 0x2345 and out_valid=0.
  - Back-to-back valid inputs yield consecutive results with 1-cycle latency.
- Async reset:
  - Pull rst_n low between clock edges after a capture -> sum=0, carry_out=0, out_valid=0 immediately.
  - These values stay held while rst_n=0, even with in_valid=1 and clk toggling.
